// File: rtl/gray_pkg.sv
// Shared constants and types for the Gray-code conversion arbiter.
package gray_pkg;

    // Default width of every binary / Gray data word.
    localparam int GRAY_WIDTH = 6;

    // Requester index: which input produced a result, also used as the
    // round-robin pointer value.
    typedef logic src_t;

    localparam src_t SRC_REQ0 = 1'b0;
    localparam src_t SRC_REQ1 = 1'b1;

endpackage

// File: rtl/gray_conv_arb_if.sv
// Handshake bundle for gray_conv_arb: two requesters in, one result out.
interface gray_conv_arb_if
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_WIDTH
);

    logic             req0_valid_i;
    logic [WIDTH-1:0] req0_bin_i;
    logic             req0_ready_o;
    logic             req1_valid_i;
    logic [WIDTH-1:0] req1_bin_i;
    logic             req1_ready_o;
    logic             out_valid_o;
    logic [WIDTH-1:0] out_gray_o;
    src_t             out_src_o;
    logic             out_ready_i;

    // Converter side.
    modport slave (
        input  req0_valid_i, req0_bin_i,
        output req0_ready_o,
        input  req1_valid_i, req1_bin_i,
        output req1_ready_o,
        output out_valid_o, out_gray_o, out_src_o,
        input  out_ready_i
    );

    // Requester / consumer side.
    modport master (
        output req0_valid_i, req0_bin_i,
        input  req0_ready_o,
        output req1_valid_i, req1_bin_i,
        input  req1_ready_o,
        input  out_valid_o, out_gray_o, out_src_o,
        output out_ready_i
    );

endinterface

// File: rtl/bin2gray.sv
// Purely combinational binary to reflected-Gray converter.
module bin2gray #(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] bin_i,
    output logic [WIDTH-1:0] gray_o
);

    // Each Gray bit is the XOR of a binary bit with its upper neighbour.
    assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/gray_conv_arb.sv
// Two requesters share one binary-to-Gray converter through a single-entry
// output register; round-robin arbitration when both are valid.
module gray_conv_arb
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_WIDTH
) (
    input  logic           clk,
    input  logic           reset_n,
    gray_conv_arb_if.slave bus
);

    logic             free;
    logic             gnt0;
    logic             gnt1;
    src_t             sel_src;
    logic [WIDTH-1:0] sel_bin;
    logic [WIDTH-1:0] sel_gray;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_gray_q,  out_gray_d;
    src_t             out_src_q,   out_src_d;
    src_t             ptr_q,       ptr_d;

    // Grant at most one requester, only when the output register can take a word.
    // Reset gates free so no ready is raised in a reset cycle.
    always_comb begin
        free    = reset_n && (!out_valid_q || bus.out_ready_i);
        gnt0    = free && bus.req0_valid_i && (!bus.req1_valid_i || ptr_q == SRC_REQ0);
        gnt1    = free && bus.req1_valid_i && (!bus.req0_valid_i || ptr_q == SRC_REQ1);
        sel_src = gnt1 ? SRC_REQ1 : SRC_REQ0;
        sel_bin = gnt1 ? bus.req1_bin_i : bus.req0_bin_i;
    end

    bin2gray #(
        .WIDTH (WIDTH)
    ) u_bin2gray (
        .bin_i  (sel_bin),
        .gray_o (sel_gray)
    );

    // Next state: load on accept (pointer flips to the other side), drop valid on a bare drain.
    always_comb begin
        out_valid_d = out_valid_q;
        out_gray_d  = out_gray_q;
        out_src_d   = out_src_q;
        ptr_d       = ptr_q;
        if (gnt0 || gnt1) begin
            out_valid_d = 1'b1;
            out_gray_d  = sel_gray;
            out_src_d   = sel_src;
            ptr_d       = (sel_src == SRC_REQ0) ? SRC_REQ1 : SRC_REQ0;
        end else if (bus.out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset; reset discards any held result.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_gray_q  <= '0;
            out_src_q   <= SRC_REQ0;
            ptr_q       <= SRC_REQ0;
        end else begin
            out_valid_q <= out_valid_d;
            out_gray_q  <= out_gray_d;
            out_src_q   <= out_src_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.req0_ready_o = gnt0;
    assign bus.req1_ready_o = gnt1;
    assign bus.out_valid_o  = out_valid_q;
    assign bus.out_gray_o   = out_gray_q;
    assign bus.out_src_o    = out_src_q;

endmodule

// File: tb/tb_gray_conv_arb.sv
// Scoreboard bench for gray_conv_arb: directed scenarios followed by a random soak.
module tb_gray_conv_arb;

    typedef struct {
        int src;
        int gray;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model state
    exp_t exp_q[$];
    int   m_ptr = 0;
    bit   m_valid = 1'b0;
    bit   m_rst = 1'b0;
    bit   g0 = 1'b0;
    bit   g1 = 1'b0;
    int   w0 = 0;
    int   w1 = 0;

    gray_conv_arb_if #(.WIDTH(6)) bus ();

    gray_conv_arb #(.WIDTH(6)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    // Model: decides who should be accepted this cycle, checks ready/valid, queues expected results.
    always @(negedge clk) begin
        int   win;
        int   b;
        bit   free;
        exp_t e;
        if (!reset_n) begin
            n_chk++;
            if (bus.req0_ready_o !== 1'b0 || bus.req1_ready_o !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_ready: got %b/%b expected 0/0", bus.req0_ready_o, bus.req1_ready_o);
            end
            m_valid = 1'b0;
            m_ptr   = 0;
            m_rst   = 1'b1;
            exp_q.delete();
            g0 = 1'b0;
            g1 = 1'b0;
            w0 = 0;
            w1 = 0;
        end else begin
            n_chk++;
            if (bus.out_valid_o !== m_valid) begin
                n_fail++;
                $display("FAIL out_valid: got %b expected %b", bus.out_valid_o, m_valid);
            end
            if (m_rst) begin
                n_chk++;
                if (bus.out_gray_o !== 6'd0 || bus.out_src_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rst_out: got gray=%0d src=%b expected 0/0", bus.out_gray_o, bus.out_src_o);
                end
                m_rst = 1'b0;
            end
            free = !m_valid || bus.out_ready_i;
            win  = -1;
            if (free) begin
                if (bus.req0_valid_i && bus.req1_valid_i) win = m_ptr;
                else if (bus.req0_valid_i)                win = 0;
                else if (bus.req1_valid_i)                win = 1;
            end
            n_chk++;
            if (bus.req0_ready_o !== (win == 0) || bus.req1_ready_o !== (win == 1)) begin
                n_fail++;
                $display("FAIL ready: got %b/%b expected %b/%b", bus.req0_ready_o, bus.req1_ready_o,
                         (win == 0), (win == 1));
            end
            g0 = (win == 0);
            g1 = (win == 1);
            if (win >= 0) begin
                b      = (win == 0) ? int'(bus.req0_bin_i) : int'(bus.req1_bin_i);
                e.src  = win;
                e.gray = b ^ (b / 2);
                exp_q.push_back(e);
                m_valid = 1'b1;
                m_ptr   = 1 - win;
                n_chk++;
                if (win == 0) begin
                    if (w0 > 2) begin
                        n_fail++;
                        $display("FAIL fair0: got %0d waits expected <=2", w0);
                    end
                    w0 = 0;
                    if (bus.req1_valid_i) w1++;
                end else begin
                    if (w1 > 2) begin
                        n_fail++;
                        $display("FAIL fair1: got %0d waits expected <=2", w1);
                    end
                    w1 = 0;
                    if (bus.req0_valid_i) w0++;
                end
            end else if (bus.out_ready_i) begin
                m_valid = 1'b0;
            end
        end
    end

    // Monitor: every presented result must match the head of the expected queue; pop on drain.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && bus.out_valid_o === 1'b1) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_extra: got gray=%0d src=%b expected no result", bus.out_gray_o, bus.out_src_o);
            end else begin
                e = exp_q[0];
                if (bus.out_gray_o !== 6'(e.gray) || bus.out_src_o !== 1'(e.src)) begin
                    n_fail++;
                    $display("FAIL sb_data: got gray=%0d src=%b expected gray=%0d src=%0d",
                             bus.out_gray_o, bus.out_src_o, e.gray, e.src);
                end
                if (bus.out_ready_i) void'(exp_q.pop_front());
            end
        end
    end

    task automatic step(input logic v0, input logic [5:0] b0, input logic v1,
                        input logic [5:0] b1, input logic ordy);
        @(posedge clk);
        #1;
        bus.req0_valid_i = v0;
        bus.req0_bin_i   = b0;
        bus.req1_valid_i = v1;
        bus.req1_bin_i   = b1;
        bus.out_ready_i  = ordy;
    endtask

    task automatic chk(input string nm, input logic v, input logic [5:0] g, input logic s);
        n_chk++;
        if (bus.out_valid_o !== v || bus.out_gray_o !== g || bus.out_src_o !== s) begin
            n_fail++;
            $display("FAIL %s: got v=%b gray=%0d src=%b expected v=%b gray=%0d src=%b",
                     nm, bus.out_valid_o, bus.out_gray_o, bus.out_src_o, v, g, s);
        end
    endtask

    task automatic rst_pulse();
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        bus.req0_valid_i = 1'b0;
        bus.req1_valid_i = 1'b0;
        bus.out_ready_i  = 1'b1;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        bus.req0_valid_i = 1'b0;
        bus.req0_bin_i   = '0;
        bus.req1_valid_i = 1'b0;
        bus.req1_bin_i   = '0;
        bus.out_ready_i  = 1'b1;

        // Reset release with req0 only, bin 5 -> Gray 7
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(1, 5, 0, 0, 1);
        reset_n = 1'b1;
        step(0, 0, 0, 0, 1);
        chk("req0_only", 1, 7, 0);

        // Both valid from reset: 6 -> 5 (src0), then 13 -> 11 (src1)
        rst_pulse();
        step(1, 6, 1, 13, 1);
        step(0, 0, 1, 13, 1);
        chk("rr_first", 1, 5, 0);
        step(0, 0, 0, 0, 1);
        chk("rr_second", 1, 11, 1);

        // Output stall with both requesters waiting; pointer now at req1
        step(1, 5, 0, 0, 1);
        step(1, 2, 1, 9, 0);
        chk("stall_a", 1, 7, 0);
        step(1, 2, 1, 9, 0);
        chk("stall_b", 1, 7, 0);
        step(1, 2, 1, 9, 1);
        chk("stall_c", 1, 7, 0);
        step(1, 2, 0, 0, 1);
        chk("stall_rel1", 1, 13, 1);
        step(0, 0, 0, 0, 1);
        chk("stall_rel0", 1, 3, 0);

        // Boundary words from req1: 63 -> 32, 0 -> 0
        step(0, 0, 1, 63, 1);
        step(0, 0, 1, 0, 1);
        chk("bin63", 1, 32, 1);
        step(0, 0, 0, 0, 1);
        chk("bin0", 1, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("drain_keep", 0, 0, 1);

        // Reset while a result is held and both requesters are valid
        step(1, 4, 1, 8, 0);
        step(1, 20, 1, 8, 0);
        chk("pre_rst", 1, 6, 0);
        reset_n = 1'b0;
        step(1, 20, 1, 8, 1);
        reset_n = 1'b1;
        chk("mid_rst", 0, 0, 0);
        step(0, 0, 1, 8, 1);
        chk("post_rst0", 1, 30, 0);
        step(0, 0, 0, 0, 1);
        chk("post_rst1", 1, 12, 1);

        // Random soak: requesters hold their word until accepted
        for (int c = 0; c < 10000; c++) begin
            @(posedge clk);
            #1;
            if (!bus.req0_valid_i || g0) begin
                bus.req0_valid_i = ($urandom_range(0, 3) != 0);
                bus.req0_bin_i   = 6'($urandom);
            end
            if (!bus.req1_valid_i || g1) begin
                bus.req1_valid_i = ($urandom_range(0, 3) != 0);
                bus.req1_bin_i   = 6'($urandom);
            end
            bus.out_ready_i = ($urandom_range(0, 3) != 0);
        end

        // Let any pending words drain, then the scoreboard must be empty
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (g0) bus.req0_valid_i = 1'b0;
            if (g1) bus.req1_valid_i = 1'b0;
            bus.out_ready_i = 1'b1;
        end
        @(negedge clk);
        n_chk++;
        if (exp_q.size() != 0 || bus.req0_valid_i || bus.req1_valid_i) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
